// File: rtl/id_imm_stage.sv
// ID-stage immediate generator with a one-entry valid/ready register toward EX.
// Also counts accepted instructions that carry no recognised immediate format.
module id_imm_stage #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned BR_SHIFT = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [31:0]       i_instr,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_flush,
  input  logic              i_out_ready,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_imm_out,
  output logic [2:0]        o_imm_type,
  output logic [CNT_W-1:0]  o_ill_cnt
);

  typedef enum logic [2:0] {
    ImmNone = 3'd0,
    ImmI    = 3'd1,
    ImmD    = 3'd2,
    ImmB    = 3'd3,
    ImmCb   = 3'd4,
    ImmSh   = 3'd5
  } imm_type_e;

  logic [63:0]       w_imm_full;
  logic [DATA_W-1:0] w_imm;
  imm_type_e         w_imm_type;
  logic              w_accept;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_imm;
  imm_type_e         r_imm_type;
  logic [CNT_W-1:0]  r_ill_cnt;

  // First match wins; extension is done at full 64 bits, shifted, then truncated.
  always_comb begin
    w_imm_full = '0;
    w_imm_type = ImmNone;
    if (i_instr[31:26] == 6'b000101) begin
      w_imm_type = ImmB;
      w_imm_full = {{38{i_instr[25]}}, i_instr[25:0]} << BR_SHIFT;
    end else if (i_instr[31:24] == 8'b10110100 || i_instr[31:24] == 8'b10110101 ||
                 i_instr[31:24] == 8'b01010100) begin
      w_imm_type = ImmCb;
      w_imm_full = {{45{i_instr[23]}}, i_instr[23:5]} << BR_SHIFT;
    end else if (i_instr[31:21] == 11'b11111000000 || i_instr[31:21] == 11'b11111000010) begin
      w_imm_type = ImmD;
      w_imm_full = {{55{i_instr[20]}}, i_instr[20:12]};
    end else if (i_instr[31:22] == 10'b1001000100 || i_instr[31:22] == 10'b1101000100 ||
                 i_instr[31:22] == 10'b1011000100 || i_instr[31:22] == 10'b1111000100) begin
      w_imm_type = ImmI;
      w_imm_full = {52'd0, i_instr[21:10]};
    end else if (i_instr[31:21] == 11'b11010011011 || i_instr[31:21] == 11'b11010011010) begin
      w_imm_type = ImmSh;
      w_imm_full = {58'd0, i_instr[15:10]};
    end
  end

  assign w_imm      = w_imm_full[DATA_W-1:0];
  assign o_in_ready = i_reset_n & ~i_flush & (~r_out_valid | i_out_ready);
  assign w_accept   = i_in_valid & o_in_ready;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_out_valid <= 1'b0;
      r_imm       <= '0;
      r_imm_type  <= ImmNone;
      r_ill_cnt   <= '0;
    end else if (i_flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_imm       <= w_imm;
      r_imm_type  <= w_imm_type;
      if (w_imm_type == ImmNone && r_ill_cnt != {CNT_W{1'b1}}) begin
        r_ill_cnt <= r_ill_cnt + 1'b1;
      end
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_imm_out   = r_imm;
  assign o_imm_type  = r_imm_type;
  assign o_ill_cnt   = r_ill_cnt;

endmodule

// File: tb/tb_id_imm_stage.sv
// Randomised bench for id_imm_stage against a cycle-level reference model of
// the decode rules and handshake, plus directed boundary cases.
module tb_id_imm_stage;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned BR_SHIFT = 2;
  localparam int unsigned CNT_W    = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [31:0]       instr = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              flush = 1'b0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] imm_out;
  logic [2:0]        imm_type;
  logic [CNT_W-1:0]  ill_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic        m_valid;
  logic [63:0] m_imm;
  int          m_type;
  int          m_cnt;

  logic [63:0] saved_imm;
  int          saved_cnt;

  id_imm_stage #(
    .DATA_W  (DATA_W),
    .BR_SHIFT(BR_SHIFT),
    .CNT_W   (CNT_W)
  ) u_dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_instr    (instr),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_flush    (flush),
    .i_out_ready(out_ready),
    .o_out_valid(out_valid),
    .o_imm_out  (imm_out),
    .o_imm_type (imm_type),
    .o_ill_cnt  (ill_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Signed value of an n-bit field, as an integer.
  function automatic longint sfield(input longint raw, input int n);
    longint v;
    v = raw;
    if (((raw >> (n - 1)) & 1) != 0) v = raw - (longint'(1) << n);
    return v;
  endfunction

  function automatic void ref_decode(input logic [31:0] ins, output logic [63:0] imm,
                                     output int t);
    longint u;
    longint v;
    u = longint'(ins);
    v = 0;
    t = 0;
    if ((u >> 26) == 5) begin
      t = 3;
      v = sfield(u % (1 << 26), 26) * (1 << BR_SHIFT);
    end else if ((u >> 24) == 'hB4 || (u >> 24) == 'hB5 || (u >> 24) == 'h54) begin
      t = 4;
      v = sfield((u / 32) % (1 << 19), 19) * (1 << BR_SHIFT);
    end else if ((u >> 21) == 'h7C0 || (u >> 21) == 'h7C2) begin
      t = 2;
      v = sfield((u / 4096) % 512, 9);
    end else if ((u >> 22) == 'h244 || (u >> 22) == 'h344 || (u >> 22) == 'h2C4 ||
                 (u >> 22) == 'h3C4) begin
      t = 1;
      v = (u / 1024) % 4096;
    end else if ((u >> 21) == 'h69B || (u >> 21) == 'h69A) begin
      t = 5;
      v = (u / 1024) % 64;
    end
    imm = 64'(v);
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = int'($urandom_range(0, 2));
    case ($urandom_range(0, 6))
      0: return {6'b000101, r[25:0]};
      1: return {(k == 0) ? 8'hB4 : (k == 1) ? 8'hB5 : 8'h54, r[23:0]};
      2: return {(k == 0) ? 11'h7C0 : 11'h7C2, r[20:0]};
      3: return {(k == 0) ? 10'h244 : (k == 1) ? 10'h344 : (k == 2) ? 10'h2C4 : 10'h3C4,
                 r[21:0]};
      4: return {(k == 0) ? 11'h69B : 11'h69A, r[20:0]};
      default: return r;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_imm   = '0;
    m_type  = 0;
    m_cnt   = 0;
  endtask

  // Inputs are already stable; check in_ready, take the edge, check registered outputs.
  task automatic cycle();
    logic        rdy;
    logic [63:0] di;
    int          dt;
    #1;
    rdy = !flush && (!m_valid || out_ready);
    check("in_ready", 64'(in_ready), 64'(rdy));
    @(posedge clk);
    ref_decode(instr, di, dt);
    if (flush) begin
      m_valid = 1'b0;
    end else if (in_valid && rdy) begin
      m_valid = 1'b1;
      m_imm   = di;
      m_type  = dt;
      if (dt == 0 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("imm_out", 64'(imm_out), m_imm);
    check("imm_type", 64'(imm_type), 64'(m_type));
    check("ill_cnt", 64'(ill_cnt), 64'(m_cnt));
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic send(input logic [31:0] ins);
    instr     = ins;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_imm_out", 64'(imm_out), 64'd0);
    check("rst_imm_type", 64'(imm_type), 64'd0);
    check("rst_ill_cnt", 64'(ill_cnt), 64'd0);
    do_reset();

    // Directed decode examples
    send(32'hF85F8041);
    check("ldur_imm", 64'(imm_out), 64'hFFFF_FFFF_FFFF_FFF8);
    check("ldur_type", 64'(imm_type), 64'd2);
    send(32'h17FFFFFF);
    check("b_imm", 64'(imm_out), 64'hFFFF_FFFF_FFFF_FFFC);
    check("b_type", 64'(imm_type), 64'd3);
    send(32'hB4000060);
    check("cbz_imm", 64'(imm_out), 64'h0000_0000_0000_000C);
    check("cbz_type", 64'(imm_type), 64'd4);
    send(32'h913FFC00);
    check("addi_imm", 64'(imm_out), 64'h0000_0000_0000_0FFF);
    check("addi_type", 64'(imm_type), 64'd1);

    // Backpressure: EX stalls 3 cycles while a new instr waits
    out_ready = 1'b0;
    cycle();
    saved_imm = m_imm;
    instr     = 32'hF8000000 | 32'h001FF000;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_imm_hold", 64'(imm_out), saved_imm);
    end
    out_ready = 1'b1;
    cycle();
    check("release_imm", 64'(imm_out), 64'hFFFF_FFFF_FFFF_FFFF);
    check("release_type", 64'(imm_type), 64'd2);

    // Flush with a valid entry held and a NONE instr incoming
    saved_cnt = m_cnt;
    instr     = 32'h0000_0000;
    in_valid  = 1'b1;
    flush     = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_ill_cnt", 64'(ill_cnt), 64'(saved_cnt));

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      instr     = gen_instr();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      cycle();
    end
    flush = 1'b0;

    // Async reset mid-stream
    instr     = 32'h17FFFFFF;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cycle();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_imm_out", 64'(imm_out), 64'd0);
    check("arst_imm_type", 64'(imm_type), 64'd0);
    check("arst_ill_cnt", 64'(ill_cnt), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd0);
    do_reset();

    // Counter saturation on a stream of NONE instructions
    instr     = 32'h0000_0000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) cycle();
    check("sat_ill_cnt", 64'(ill_cnt), 64'd255);
    check("sat_imm_out", 64'(imm_out), 64'd0);
    check("sat_imm_type", 64'(imm_type), 64'd0);
    in_valid = 1'b0;
    cycle();
    check("sat_drain_valid", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
